// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      WAIT_CLK,
      SEND,
      ACK,
      WAIT_IDLE,
      ERROR
   } ps2_state_t;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;
   localparam int CNT_W      = 20;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_pin_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins, plus a clock falling-edge pulse.
module ps2_pin_sync (
   input  logic clock,
   input  logic reset,
   input  logic clk_pin,
   input  logic data_pin,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic clk_p0, clk_p1, clk_p2;
   logic data_p0, data_p1;

   // Flops preset to the idle bus level so leaving reset never fakes a falling edge
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_p0  <= 1'b1;
         clk_p1  <= 1'b1;
         clk_p2  <= 1'b1;
         data_p0 <= 1'b1;
         data_p1 <= 1'b1;
      end else begin
         clk_p0  <= clk_pin;
         clk_p1  <= clk_p0;
         clk_p2  <= clk_p1;
         data_p0 <= data_pin;
         data_p1 <= data_p0;
      end
   end

   assign clk_s    = clk_p1;
   assign data_s   = data_p1;
   assign clk_fall = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int RTS_CYCLES     = 20,
   parameter int START_TIMEOUT  = 750000,
   parameter int XFER_TIMEOUT   = 100000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST   = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
   localparam logic [3:0]       STOP_IDX   = 4'(FRAME_BITS - 2);

   ps2_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        xfer_cnt;
   logic [3:0]              bit_cnt;
   logic [FRAME_BITS-2:0]   shift;
   logic                    clk_s, data_s, clk_fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   ps2_pin_sync u_sync (
      .clock    (clock),
      .reset    (reset),
      .clk_pin  (ps2_clk_in),
      .data_pin (ps2_data_in),
      .clk_s    (clk_s),
      .data_s   (data_s),
      .clk_fall (clk_fall)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         xfer_cnt    <= '0;
         bit_cnt     <= '0;
         tx_ready    <= 1'b0;
         busy        <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         cnt      <= sat_inc(cnt);
         case (state)
            IDLE: begin
               busy        <= 1'b0;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               tx_ready    <= 1'b1;
               cnt         <= '0;
               if (tx_valid && tx_ready) begin
                  shift      <= {1'b1, odd_parity(tx_data), tx_data};
                  tx_ready   <= 1'b0;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  state      <= INHIBIT;
               end
            end
            // Falls seen here are self-inflicted by our own clock pull-down
            INHIBIT: begin
               if (cnt == INH_LAST) begin
                  ps2_data_oe <= 1'b1;
                  cnt         <= '0;
                  state       <= RTS;
               end
            end
            RTS: begin
               if (cnt == RTS_LAST) begin
                  ps2_clk_oe <= 1'b0;
                  cnt        <= '0;
                  state      <= WAIT_CLK;
               end
            end
            WAIT_CLK: begin
               if (clk_fall) begin
                  ps2_data_oe <= ~shift[0];
                  bit_cnt     <= 4'd1;
                  xfer_cnt    <= '0;
                  cnt         <= '0;
                  state       <= SEND;
               end else if (cnt >= START_LAST) begin
                  ps2_data_oe <= 1'b0;
                  tx_error    <= 1'b1;
                  cnt         <= '0;
                  state       <= ERROR;
               end
            end
            SEND: begin
               xfer_cnt <= sat_inc(xfer_cnt);
               if (clk_fall) begin
                  ps2_data_oe <= ~shift[bit_cnt];
                  bit_cnt     <= bit_cnt + 4'd1;
                  if (bit_cnt == STOP_IDX) begin
                     cnt   <= '0;
                     state <= ACK;
                  end
               end else if (xfer_cnt >= XFER_LAST) begin
                  ps2_data_oe <= 1'b0;
                  tx_error    <= 1'b1;
                  cnt         <= '0;
                  state       <= ERROR;
               end
            end
            // Device pulls data low before fall 11 to acknowledge
            ACK: begin
               xfer_cnt <= sat_inc(xfer_cnt);
               if (clk_fall) begin
                  cnt <= '0;
                  if (!data_s) begin
                     state <= WAIT_IDLE;
                  end else begin
                     tx_error <= 1'b1;
                     state    <= ERROR;
                  end
               end else if (xfer_cnt >= XFER_LAST) begin
                  tx_error <= 1'b1;
                  cnt      <= '0;
                  state    <= ERROR;
               end
            end
            WAIT_IDLE: begin
               if (clk_s && data_s) begin
                  if (cnt == CNT_W'(1)) begin
                     tx_done  <= 1'b1;
                     busy     <= 1'b0;
                     tx_ready <= 1'b1;
                     cnt      <= '0;
                     state    <= IDLE;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ERROR: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               tx_ready    <= 1'b1;
               cnt         <= '0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
